// File: rtl/hack_data_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hack_data_mem : Hack data RAM, screen shadow RAM with display write FIFO,
//                 and keyboard register.  Rev 1.0
// ---------------------------------------------------------------------------
module hack_data_mem #(
  parameter int RAM_WORDS  = 16384,
  parameter int SCR_WORDS  = 8192,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [14:0]                   addressM,
  input  logic                          writeM,
  input  logic [15:0]                   outM,
  output logic [15:0]                   inM,
  output logic                          stall,
  input  logic                          kbd_valid,
  input  logic [15:0]                   kbd_code,
  output logic                          scr_valid,
  input  logic                          scr_ready,
  output logic [12:0]                   scr_addr,
  output logic [15:0]                   scr_data,
  output logic [$clog2(FIFO_DEPTH):0]   scr_level
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCR_WORDS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);

  logic [15:0] ram [RAM_WORDS];
  logic [15:0] scr [SCR_WORDS];
  logic [12:0] fifo_addr [FIFO_DEPTH];
  logic [15:0] fifo_data [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic [15:0]      kbd_reg;

  logic              sel_ram;
  logic              sel_scr;
  logic              sel_kbd;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic [RAM_AW-1:0] ram_idx;
  logic [SCR_AW-1:0] scr_idx;

  assign sel_ram = ~addressM[14];
  assign sel_scr = (addressM[14:13] == 2'b10);
  assign sel_kbd = (addressM == 15'h6000);
  assign ram_idx = addressM[RAM_AW-1:0];
  assign scr_idx = addressM[SCR_AW-1:0];

  // Full is taken from registered level only, so a same-cycle pop never frees a slot.
  assign fifo_full = (level == FULL_LEVEL);
  assign stall     = writeM & sel_scr & fifo_full;
  assign push      = writeM & sel_scr & ~fifo_full & ~rst;
  assign scr_valid = (level != '0);
  assign pop       = scr_valid & scr_ready & ~rst;

  assign scr_addr  = fifo_addr[rd_ptr];
  assign scr_data  = fifo_data[rd_ptr];
  assign scr_level = level;

  always_comb begin
    inM = 16'h0000;
    if (sel_ram) begin
      inM = ram[ram_idx];
    end else if (sel_scr) begin
      inM = scr[scr_idx];
    end else if (sel_kbd) begin
      inM = kbd_reg;
    end
  end

  // Storage arrays carry no reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (writeM && sel_ram) begin
      ram[ram_idx] <= outM;
    end
    if (push) begin
      scr[scr_idx]      <= outM;
      fifo_addr[wr_ptr] <= addressM[12:0];
      fifo_data[wr_ptr] <= outM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      kbd_reg <= 16'h0000;
    end else begin
      if (kbd_valid) begin
        kbd_reg <= kbd_code;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/hack_data_mem.md
Name: hack_data_mem

Overview:
- Data-memory and memory-mapped I/O stage directly downstream of the CPU control block.
- Consumes addressM/writeM and the ALU result (outM); returns inM combinationally in the same cycle, as the CPU's y-operand mux requires.
- Implements the Hack memory map: general RAM, a screen shadow RAM with a write FIFO toward the display driver, and a keyboard register.
- Exports a stall when a screen write cannot be accepted.

Parameters:
- RAM_WORDS, 16384, general RAM depth in words; address range 0x0000-0x3FFF.
- SCR_WORDS, 8192, screen shadow RAM depth in words; address range 0x4000-0x5FFF.
- FIFO_DEPTH, 8, screen-write FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- addressM  in  15  CPU data address, taken from the A register.
- writeM  in  1  CPU write enable for the current cycle.
- outM  in  16  CPU write data (ALU result).
- inM  out  16  read data for addressM, combinational.
- stall  out  1  CPU must hold PC and all registers this cycle; the write is not committed.
- kbd_valid  in  1  one-cycle pulse: new keyboard state is present.
- kbd_code  in  16  key code; 0 means no key pressed.
- scr_valid  out  1  FIFO head entry is valid.
- scr_ready  in  1  display driver accepts the head entry.
- scr_addr  out  13  head entry screen word offset (addressM - 0x4000).
- scr_data  out  16  head entry pixel word.
- scr_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Decode on addressM[14:13]:
  - 00 or 01: RAM.
  - 10: screen.
  - 11: keyboard if addressM == 0x6000, otherwise unmapped.
- Reads (combinational, no latency):
  - inM = RAM[addr], SCR[addr-0x4000], or kbd_reg, per decode.
  - Unmapped addresses read 0x0000.
  - A read in the same cycle as a write to the same address returns the old value. The new value is visible from the next cycle.
- RAM write: when writeM is high and decode is RAM, RAM[addr] <= outM at the clock edge. RAM never stalls.
- Screen write: accepted when writeM is high, decode is screen, and the FIFO is not full.
  - On acceptance: SCR[addr] <= outM and {addr[12:0], outM} is pushed to the FIFO in the same edge.
- stall = writeM & decode==screen & fifo_full. This is purely combinational from registered FIFO state.
  - While stall is high: no shadow write and no push. The CPU holds, so the identical write is re-presented.
  - There is no full-bypass: a pop in the same cycle as full does not allow a push that cycle. Stall deasserts the cycle after the pop.
- Writes to the keyboard or unmapped addresses are ignored silently, with no stall.
- FIFO behaviour:
  - Circular buffer with wrapping read/write pointers.
  - Pop on scr_valid & scr_ready.
  - scr_valid = (level != 0). scr_addr and scr_data show the head entry and stay stable while scr_valid & !scr_ready.
  - Simultaneous push and pop with a non-empty, non-full FIFO leaves level unchanged.
  - Push into an empty FIFO: scr_valid rises the next cycle. There is no same-cycle fall-through.
  - scr_ready while empty has no effect.
- Keyboard:
  - On kbd_valid, kbd_reg <= kbd_code at the edge. It holds until the next kbd_valid.
  - kbd_code = 0 represents key release.
  - CPU reads see the new value starting the cycle after the pulse.
- Reset values:
  - kbd_reg = 0.
  - FIFO pointers = 0, level = 0, so scr_valid = 0.
  - Consequently stall = 0 and scr_level = 0.
  - RAM and screen shadow contents are not reset.
  - Reset mid-operation discards all queued FIFO entries. Writes committed before the reset edge remain in RAM/SCR.
- Priority: rst overrides kbd_valid, push and pop in the same cycle.

Test Plan:
- RAM write/read: write 0x1234 to 0x0010 (writeM=1) -> same-cycle inM at 0x0010 shows the old value; next cycle inM=0x1234. Unmapped address 0x7000 reads 0x0000, and a write to it is dropped.
- Screen path: write 0xFFFF to 0x4005 with scr_ready=0 -> next cycle scr_valid=1, scr_addr=0x0005, scr_data=0xFFFF, scr_level=1; inM at 0x4005 = 0xFFFF.
- FIFO full/stall: 8 screen writes with scr_ready=0 -> level=8; 9th write (0x4100, 0xAAAA) -> stall=1 and SCR[0x100] unchanged. Pulse scr_ready for 1 cycle -> stall=0 the next cycle, write accepted, level=8.
- Order/wrap: stream 20 writes with scr_ready toggling randomly -> pops match push order exactly, no loss or duplication; simultaneous push+pop keeps level constant.
- Keyboard: kbd_valid with 0x0083 -> inM at 0x6000 = 0x0083 the following cycle; a CPU write to 0x6000 leaves it unchanged; kbd_valid with 0 -> reads 0.
- Reset mid-operation: 3 entries queued, assert rst one cycle -> scr_valid=0, level=0, kbd_reg=0, stall=0; previously written RAM word still reads back.
